// File: rtl/conv1d_sequencer.sv
// Command-level sequencer for the conv1d accumulator engine: configures a job,
// then walks every output position (set x, go, poll, read) and streams the results.
module conv1d_sequencer #(
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_offset,
  input  logic [DATA_W-1:0] cfg_width,
  input  logic [DATA_W-1:0] cfg_depth,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [6:0]        eng_cmd,
  output logic [DATA_W-1:0] eng_inp0,
  output logic [DATA_W-1:0] eng_inp1,
  input  logic [DATA_W-1:0] eng_ret,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_x,
  output logic              res_last
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CFG_OFS  = 4'd1,
    S_CFG_W    = 4'd2,
    S_CFG_D    = 4'd3,
    S_SET_X    = 4'd4,
    S_GO       = 4'd5,
    S_POLL     = 4'd6,
    S_POLL_CHK = 4'd7,
    S_GAP      = 4'd8,
    S_READ     = 4'd9,
    S_READ_CHK = 4'd10,
    S_EMIT     = 4'd11
  } state_t;

  localparam logic [6:0] CMD_NOP  = 7'd0;
  localparam logic [6:0] CMD_OFS  = 7'd20;
  localparam logic [6:0] CMD_W    = 7'd25;
  localparam logic [6:0] CMD_D    = 7'd26;
  localparam logic [6:0] CMD_SETX = 7'd44;
  localparam logic [6:0] CMD_GO   = 7'd41;
  localparam logic [6:0] CMD_POLL = 7'd45;
  localparam logic [6:0] CMD_READ = 7'd43;

  localparam logic [DATA_W-1:0] ZERO        = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE         = DATA_W'(1);
  localparam logic [DATA_W-1:0] TIMEOUT_LIM = DATA_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] GAP_LIM     = DATA_W'(POLL_GAP - 1);
  localparam logic              HAS_GAP     = (POLL_GAP > 0);

  state_t            state_r, state_s;
  logic [DATA_W-1:0] x_r, x_s;
  logic [DATA_W-1:0] poll_cnt_r, poll_cnt_s;
  logic [DATA_W-1:0] gap_cnt_r, gap_cnt_s;
  logic [DATA_W-1:0] width_r, depth_r;
  logic              done_s, err_s, load_cfg_s;
  logic              last_x_s, poll_phase_s, timeout_s;
  logic [6:0]        cmd_s;
  logic [DATA_W-1:0] inp1_s;

  logic [6:0]        eng_cmd_r;
  logic [DATA_W-1:0] eng_inp1_r;
  logic              busy_r, done_r, err_r;
  logic              res_valid_r, res_last_r;
  logic [DATA_W-1:0] res_data_r, res_x_r;

  assign last_x_s     = (x_r == (width_r - ONE));
  assign poll_phase_s = (state_r == S_POLL) || (state_r == S_POLL_CHK) || (state_r == S_GAP);
  // A finished flag seen on the very last poll cycle still wins over the timeout.
  assign timeout_s    = poll_phase_s && (poll_cnt_r == TIMEOUT_LIM) &&
                        !((state_r == S_POLL_CHK) && eng_ret[0]);

  // Next-state, counter and status decisions
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    poll_cnt_s = poll_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    done_s     = 1'b0;
    err_s      = err_r;
    load_cfg_s = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_s    = S_CFG_OFS;
            err_s      = 1'b0;
            load_cfg_s = 1'b1;
            x_s        = ZERO;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_CFG_OFS: state_s = S_CFG_W;
        S_CFG_W:   state_s = S_CFG_D;
        S_CFG_D: begin
          if (width_r == ZERO) begin
            state_s = S_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = S_SET_X;
          end
        end
        S_SET_X: state_s = S_GO;
        S_GO: begin
          state_s    = S_POLL;
          poll_cnt_s = ZERO;
        end
        S_POLL: begin
          poll_cnt_s = poll_cnt_r + ONE;
          if (timeout_s) begin
            state_s = S_IDLE;
            err_s   = 1'b1;
          end else begin
            state_s = S_POLL_CHK;
          end
        end
        S_POLL_CHK: begin
          poll_cnt_s = poll_cnt_r + ONE;
          if (eng_ret[0]) begin
            state_s = S_READ;
          end else if (timeout_s) begin
            state_s = S_IDLE;
            err_s   = 1'b1;
          end else if (HAS_GAP) begin
            state_s   = S_GAP;
            gap_cnt_s = ZERO;
          end else begin
            state_s = S_POLL;
          end
        end
        S_GAP: begin
          poll_cnt_s = poll_cnt_r + ONE;
          if (timeout_s) begin
            state_s = S_IDLE;
            err_s   = 1'b1;
          end else if (gap_cnt_r == GAP_LIM) begin
            state_s = S_POLL;
          end else begin
            gap_cnt_s = gap_cnt_r + ONE;
          end
        end
        S_READ:     state_s = S_READ_CHK;
        S_READ_CHK: state_s = S_EMIT;
        S_EMIT: begin
          if (res_ready) begin
            if (last_x_s) begin
              state_s = S_IDLE;
              done_s  = 1'b1;
            end else begin
              x_s     = x_r + ONE;
              state_s = S_SET_X;
            end
          end else begin
            state_s = S_EMIT;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Engine command and operand belonging to the state being entered
  always_comb begin
    cmd_s  = CMD_NOP;
    inp1_s = ZERO;
    case (state_s)
      S_CFG_OFS: begin cmd_s = CMD_OFS;  inp1_s = cfg_offset; end
      S_CFG_W:   begin cmd_s = CMD_W;    inp1_s = width_r;    end
      S_CFG_D:   begin cmd_s = CMD_D;    inp1_s = depth_r;    end
      S_SET_X:   begin cmd_s = CMD_SETX; inp1_s = x_s;        end
      S_GO:      cmd_s = CMD_GO;
      S_POLL:    cmd_s = CMD_POLL;
      S_READ:    cmd_s = CMD_READ;
      default:   cmd_s = CMD_NOP;
    endcase
  end

  // FSM state, job configuration and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      x_r        <= ZERO;
      poll_cnt_r <= ZERO;
      gap_cnt_r  <= ZERO;
      width_r    <= ZERO;
      depth_r    <= ZERO;
    end else begin
      state_r    <= state_s;
      x_r        <= x_s;
      poll_cnt_r <= poll_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      if (load_cfg_s) begin
        width_r <= cfg_width;
        depth_r <= cfg_depth;
      end
    end
  end

  // Registered engine bus, status and result stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cmd_r   <= CMD_NOP;
      eng_inp1_r  <= ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= ZERO;
      res_x_r     <= ZERO;
      res_last_r  <= 1'b0;
    end else begin
      eng_cmd_r   <= cmd_s;
      eng_inp1_r  <= inp1_s;
      busy_r      <= (state_s != S_IDLE);
      done_r      <= done_s;
      err_r       <= err_s;
      res_valid_r <= (state_s == S_EMIT);
      if ((state_r == S_READ_CHK) && !abort) begin
        res_data_r <= eng_ret;
        res_x_r    <= x_r;
        res_last_r <= last_x_s;
      end
    end
  end

  assign eng_cmd   = eng_cmd_r;
  assign eng_inp0  = ZERO;
  assign eng_inp1  = eng_inp1_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_x     = res_x_r;
  assign res_last  = res_last_r;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Scoreboard bench for conv1d_sequencer with a behavioural engine stand-in;
// expected results are queued at job launch and popped by an independent monitor.
module tb_conv1d_sequencer;
  localparam int DW = 32;
  localparam int PG = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, res_ready;
  logic [DW-1:0] cfg_offset, cfg_width, cfg_depth, eng_ret;
  logic          busy, done, err, res_valid, res_last;
  logic [6:0]    eng_cmd;
  logic [DW-1:0] eng_inp0, eng_inp1, res_data, res_x;

  conv1d_sequencer #(.DATA_W(DW), .POLL_GAP(PG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_offset(cfg_offset), .cfg_width(cfg_width), .cfg_depth(cfg_depth),
    .busy(busy), .done(done), .err(err),
    .eng_cmd(eng_cmd), .eng_inp0(eng_inp0), .eng_inp1(eng_inp1), .eng_ret(eng_ret),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_x(res_x), .res_last(res_last)
  );

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] d; logic [DW-1:0] x; logic l;} exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int n_setx = 0;
  int eng_lat = 0;
  bit eng_never = 1'b0;
  bit stall_mode = 1'b0;
  int stall_cnt = 0;
  logic [DW-1:0] off_e = '0, w_e = '0, d_e = '0, x_e = '0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Result value the engine stand-in produces for a configured position.
  function automatic logic [DW-1:0] acc_model(input logic [DW-1:0] off, w, d, x);
    return (off * 32'd3) ^ (d << 5) ^ (x * 32'h9E37_79B9) ^ w;
  endfunction

  // Engine stand-in: latches config/x, answers polls after eng_lat cycles, returns one cycle later.
  initial begin
    int ecyc = 0, go_cyc = 0, last_poll = 0;
    bit nf_last = 1'b0, fin;
    logic [6:0] c, prevc = 7'd0;
    logic [DW-1:0] i1, nxt;
    eng_ret = '0;
    forever begin
      @(negedge clk);
      c = eng_cmd; i1 = eng_inp1; ecyc++;
      nxt = $urandom;
      if (c != 7'd0) check(eng_inp0 == '0, "inp0_zero", eng_inp0, 0);
      if (prevc == 7'd41) check(c == 7'd45, "go_then_poll", c, 45);
      case (c)
        7'd20: off_e = i1;
        7'd25: w_e = i1;
        7'd26: d_e = i1;
        7'd44: begin x_e = i1; n_setx++; end
        7'd41: begin go_cyc = ecyc; nf_last = 1'b0; end
        7'd45: begin
          if (nf_last) check((ecyc - last_poll) == PG + 2, "poll_spacing", ecyc - last_poll, PG + 2);
          fin = !eng_never && ((ecyc - go_cyc) >= eng_lat);
          nf_last = !fin; last_poll = ecyc;
          nxt[0] = fin;
        end
        7'd43: nxt = acc_model(off_e, w_e, d_e, x_e);
        default: ;
      endcase
      prevc = c;
      @(posedge clk); #1;
      eng_ret = nxt;
    end
  end

  // Consumer ready: random, except a 10-cycle hold on position 1 in stall mode.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode && res_valid && res_x == 1 && stall_cnt < 10) begin
        res_ready = 1'b0; stall_cnt++;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and watches stream/done rules.
  initial begin
    bit prev_stall = 1'b0, post_acc = 1'b0, prev_done = 1'b0;
    logic [DW-1:0] pd = '0, px = '0;
    logic pl = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (post_acc) check(!res_valid, "valid_drop_after_accept", res_valid, 0);
      post_acc = 1'b0;
      if (prev_stall) begin
        check(res_valid && res_data == pd && res_x == px && res_last == pl, "stall_stable",
              {res_data, res_x}, {pd, px});
      end
      prev_stall = 1'b0;
      if (res_valid) check(eng_cmd == 7'd0, "nop_in_emit", eng_cmd, 0);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_result", res_x, 0);
        end else begin
          e = sb.pop_front();
          check(res_data == e.d, "res_data", res_data, e.d);
          check(res_x == e.x, "res_x", res_x, e.x);
          check(res_last == e.l, "res_last", res_last, e.l);
        end
        post_acc = 1'b1;
      end else if (res_valid) begin
        prev_stall = 1'b1; pd = res_data; px = res_x; pl = res_last;
      end
      if (done) begin
        done_cnt++;
        check(!prev_done, "done_single_pulse", prev_done, 0);
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
    check(!busy, "idle_before_start", busy, 0);
  endtask

  task automatic pulse_start(input logic [DW-1:0] off, w, dep);
    @(posedge clk); #1;
    start = 1'b1; cfg_offset = off; cfg_width = w; cfg_depth = dep;
    @(posedge clk); #1;
    start = 1'b0; cfg_offset = $urandom; cfg_width = $urandom; cfg_depth = $urandom;
  endtask

  task automatic check_cfg_cmds(input logic [DW-1:0] off, w, dep);
    @(negedge clk);
    check(eng_cmd == 7'd20 && eng_inp1 == off, "cfg_ofs", {eng_cmd, eng_inp1}, {7'd20, off});
    check(busy && !err, "busy_at_start", {busy, err}, 2'b10);
    @(negedge clk);
    check(eng_cmd == 7'd25 && eng_inp1 == w, "cfg_w", {eng_cmd, eng_inp1}, {7'd25, w});
    @(negedge clk);
    check(eng_cmd == 7'd26 && eng_inp1 == dep, "cfg_d", {eng_cmd, eng_inp1}, {7'd26, dep});
  endtask

  task automatic run_job(input logic [DW-1:0] off, w, dep, input int lat, input bit poke);
    int dc;
    exp_t e;
    wait_idle();
    eng_never = 1'b0; eng_lat = lat;
    for (int x = 0; x < int'(w); x++) begin
      e.d = acc_model(off, w, dep, DW'(x)); e.x = DW'(x); e.l = (x == int'(w) - 1);
      sb.push_back(e);
    end
    dc = done_cnt;
    pulse_start(off, w, dep);
    check_cfg_cmds(off, w, dep);
    if (poke) pulse_start(32'hDEAD_BEEF, 32'd7, 32'd9);
    for (int i = 0; i < 20000 && done_cnt == dc; i++) @(negedge clk);
    check(done_cnt == dc + 1, "done_count", done_cnt - dc, 1);
    check(!busy, "idle_after_done", busy, 0);
    check(sb.size() == 0, "all_results_seen", sb.size(), 0);
    @(negedge clk);
    check(!done && done_cnt == dc + 1, "done_once", done_cnt - dc, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check(!busy && !done && !err, {tag, "_status"}, {busy, done, err}, 0);
    check(eng_cmd == 7'd0 && eng_inp0 == '0 && eng_inp1 == '0, {tag, "_eng"}, {eng_cmd, eng_inp1}, 0);
    check(!res_valid && res_data == '0 && res_x == '0 && !res_last, {tag, "_res"},
          {res_valid, res_last, res_data}, 0);
  endtask

  initial begin
    int dc, n, sx;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_offset = '0; cfg_width = '0; cfg_depth = '0;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(32'd128, 32'd3, 32'd4, 40, 1'b0);

    stall_mode = 1'b1; stall_cnt = 0;
    run_job($urandom, 32'd3, $urandom_range(1, 64), $urandom_range(0, 20), 1'b1);
    stall_mode = 1'b0;
    check(stall_cnt == 10, "stall_cycles", stall_cnt, 10);

    sx = n_setx;
    run_job($urandom, 32'd0, $urandom, 5, 1'b0);
    check(n_setx == sx, "width0_no_setx", n_setx - sx, 0);

    for (int j = 0; j < 4; j++)
      run_job($urandom, $urandom_range(1, 4), $urandom, $urandom_range(0, 45), 1'b0);

    // Engine that never finishes: timeout after TO poll cycles.
    wait_idle();
    eng_never = 1'b1; dc = done_cnt;
    pulse_start(32'd5, 32'd2, 32'd3);
    check_cfg_cmds(32'd5, 32'd2, 32'd3);
    for (int i = 0; i < 100; i++) begin
      if (eng_cmd == 7'd45) break;
      @(negedge clk);
    end
    n = 0;
    while (!err && n < 1000) begin @(negedge clk); n++; end
    check(n == TO, "timeout_cycles", n, TO);
    check(!busy && eng_cmd == 7'd0, "timeout_idle", {busy, eng_cmd}, 0);
    repeat (3) @(negedge clk);
    check(err && done_cnt == dc, "err_sticky_no_done", {err, 8'(done_cnt - dc)}, 9'h100);
    eng_never = 1'b0;
    run_job($urandom, 32'd2, $urandom, 10, 1'b0);

    // Abort (with a simultaneous start) during polling of x=1.
    wait_idle();
    eng_lat = 20; dc = done_cnt;
    e.d = acc_model(32'd77, 32'd3, 32'd6, 32'd0); e.x = '0; e.l = 1'b0;
    sb.push_back(e);
    pulse_start(32'd77, 32'd3, 32'd6);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (x_e == 32'd1 && eng_cmd == 7'd45) break;
    end
    check(x_e == 32'd1 && eng_cmd == 7'd45, "reach_poll_x1", {x_e, 25'd0, eng_cmd}, 45);
    @(posedge clk); #1; abort = 1'b1; start = 1'b1;
    @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check(!busy && eng_cmd == 7'd0 && !res_valid && !done, "abort_idle",
          {busy, eng_cmd, res_valid, done}, 0);
    check(!err, "abort_err_unchanged", err, 0);
    repeat (3) @(negedge clk);
    check(!busy && done_cnt == dc && sb.size() == 0, "abort_no_done", {busy, 8'(done_cnt - dc)}, 0);
    run_job($urandom, 32'd2, $urandom, $urandom_range(0, 30), 1'b0);

    // Asynchronous reset during READ_CHK.
    wait_idle();
    eng_lat = 5;
    pulse_start(32'd9, 32'd2, 32'd2);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (eng_cmd == 7'd43) break;
    end
    @(posedge clk); #1;
    check(busy && eng_cmd == 7'd0, "in_read_chk", {busy, eng_cmd}, 8'h80);
    rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job($urandom, 32'd1, $urandom, $urandom_range(0, 30), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
